// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax write-back path: FSM states, beat geometry
// and the burst-length helper used when splitting a job into write-master commands.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } wr_state_e;

  localparam int LANES          = 4;
  localparam int BYTES_PER_BEAT = 16;
  localparam int ADDR_W         = 32;

  function automatic logic [ADDR_W-1:0] burst_beats(input logic [ADDR_W-1:0] rem,
                                                    input int unsigned       max_beats);
    logic [ADDR_W-1:0] cap;
    cap = ADDR_W'(max_beats);
    return (rem > cap) ? cap : rem;
  endfunction

  function automatic logic [ADDR_W-1:0] burst_len(input logic [ADDR_W-1:0] rem,
                                                  input int unsigned       max_beats);
    return burst_beats(rem, max_beats) * ADDR_W'(BYTES_PER_BEAT);
  endfunction

endpackage

// File: rtl/softmax_word_packer.sv
// Packs result words LSB lane first into bus beats and holds a completed beat
// until the write-master user buffer can take it.
module softmax_word_packer
  import softmax_pkg::*;
#(
  parameter int DW  = 32,
  parameter int XDW = LANES * DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [DW-1:0]  word,
  input  logic           word_acc,
  input  logic           word_last,
  input  logic           buf_full,
  output logic           can_take,
  output logic           buf_write,
  output logic [XDW-1:0] buf_data,
  output logic           pending
);

  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0] lane_p0;
  logic [XDW-1:0]    pack_p0;
  logic              vld_p1;
  logic              push;

  assign push      = vld_p1 & ~buf_full;
  // A word may land in the same cycle the previous beat leaves.
  assign can_take  = ~vld_p1 | push;
  assign buf_write = push;
  assign buf_data  = pack_p0;
  assign pending   = vld_p1;

  // ---- stage p0: lane fill / p1: completed beat awaiting push ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_p0 <= '0;
      pack_p0 <= '0;
      vld_p1  <= 1'b0;
    end else if (clr) begin
      lane_p0 <= '0;
      pack_p0 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (push)
        vld_p1 <= 1'b0;
      if (word_acc) begin
        // Lane 0 restarts the beat, zeroing lanes a short final beat never fills.
        if (lane_p0 == '0)
          pack_p0 <= XDW'(word);
        else
          pack_p0[lane_p0*DW +: DW] <= word;
        if (lane_p0 == LANE_W'(LANES-1) || word_last) begin
          vld_p1  <= 1'b1;
          lane_p0 <= '0;
        end else begin
          lane_p0 <= lane_p0 + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/softmax_wr_pack.sv
// Softmax write-back: packs result words into beats and sequences write-master bursts.
// Optional SOFTMAX_WR_PERF_EN adds perf_stall, counting cycles a complete beat waits on a full buffer.
module softmax_wr_pack
  import softmax_pkg::*;
#(
  parameter int DW        = 32,
  parameter int XAW       = ADDR_W,
  parameter int XDW       = LANES * DW,
  parameter int MAX_BEATS = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           param_ena,
  input  logic [XAW-1:0] param_waddr,
  input  logic [XAW-1:0] param_iolen,
  input  logic [DW-1:0]  res_data,
  input  logic           res_valid,
  output logic           res_ready,
  output logic           wmst_fixed_location,
  output logic [XAW-1:0] wmst_write_base,
  output logic [XAW-1:0] wmst_write_length,
  output logic           wmst_go,
  input  logic           wmst_done,
  output logic           wmst_user_write_buffer,
  output logic [XDW-1:0] wmst_user_buffer_data,
  input  logic           wmst_user_buffer_full,
  output logic           busy,
  output logic           job_done
`ifdef SOFTMAX_WR_PERF_EN
  ,
  output logic [XAW-1:0] perf_stall
`endif
);

  wr_state_e      state;
  logic           ena_p1;
  logic           done_p1;
  logic [XAW-1:0] cur_addr;
  logic [XAW-1:0] beats_rem;
  logic [XAW-1:0] words_rem;
  logic [XAW-1:0] job_beats;
  logic [XAW-1:0] cmd_beats;
  logic [XAW-1:0] cmd_len;
  logic           start;
  logic           done_rise;
  logic           word_acc;
  logic           pk_can_take;
  logic           pk_pending;

  assign start     = param_ena & ~ena_p1 & (state == IDLE);
  assign done_rise = wmst_done & ~done_p1;
  assign job_beats = (param_iolen >> 2) + XAW'(|param_iolen[1:0]);
  assign cmd_beats = XAW'(burst_beats(ADDR_W'(beats_rem), MAX_BEATS));
  assign cmd_len   = XAW'(burst_len(ADDR_W'(beats_rem), MAX_BEATS));

  assign busy                = (state != IDLE);
  assign res_ready           = busy & (words_rem != '0) & pk_can_take;
  assign word_acc            = res_valid & res_ready;
  assign wmst_fixed_location = 1'b0;

  // ---- command sequencing: one go per burst, advance on done rising edge ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      ena_p1            <= 1'b0;
      done_p1           <= 1'b0;
      cur_addr          <= '0;
      beats_rem         <= '0;
      words_rem         <= '0;
      wmst_go           <= 1'b0;
      wmst_write_base   <= '0;
      wmst_write_length <= '0;
      job_done          <= 1'b0;
    end else begin
      ena_p1   <= param_ena;
      done_p1  <= wmst_done;
      wmst_go  <= 1'b0;
      job_done <= 1'b0;

      if (start)
        words_rem <= param_iolen;
      else if (word_acc)
        words_rem <= words_rem - XAW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= param_waddr;
            beats_rem <= job_beats;
            state     <= (param_iolen == '0) ? FINISH : CMD;
          end
        end
        CMD: begin
          wmst_go           <= 1'b1;
          wmst_write_base   <= cur_addr;
          wmst_write_length <= cmd_len;
          cur_addr          <= cur_addr + cmd_len;
          beats_rem         <= beats_rem - cmd_beats;
          state             <= WAIT;
        end
        WAIT: begin
          if (done_rise)
            state <= (beats_rem != '0) ? CMD : FINISH;
        end
        FINISH: begin
          if (words_rem == '0 && !pk_pending) begin
            job_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  softmax_word_packer #(
    .DW  (DW),
    .XDW (XDW)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .word      (res_data),
    .word_acc  (word_acc),
    .word_last (words_rem == XAW'(1)),
    .buf_full  (wmst_user_buffer_full),
    .can_take  (pk_can_take),
    .buf_write (wmst_user_write_buffer),
    .buf_data  (wmst_user_buffer_data),
    .pending   (pk_pending)
  );

`ifdef SOFTMAX_WR_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_stall <= '0;
    else if (start)
      perf_stall <= '0;
    else if (pk_pending && wmst_user_buffer_full)
      perf_stall <= perf_stall + XAW'(1);
  end
`endif

endmodule

// File: tb/tb_softmax_wr_pack.sv
// Directed bench for softmax_wr_pack with a simple write-master model and word feeder.
module tb_softmax_wr_pack;

  localparam int DW        = 32;
  localparam int XAW       = 32;
  localparam int XDW       = 128;
  localparam int MAX_BEATS = 32;

  logic           clk;
  logic           rst;
  logic           param_ena;
  logic [XAW-1:0] param_waddr;
  logic [XAW-1:0] param_iolen;
  logic [DW-1:0]  res_data;
  logic           res_valid;
  logic           res_ready;
  logic           wmst_fixed_location;
  logic [XAW-1:0] wmst_write_base;
  logic [XAW-1:0] wmst_write_length;
  logic           wmst_go;
  logic           wmst_done;
  logic           wmst_user_write_buffer;
  logic [XDW-1:0] wmst_user_buffer_data;
  logic           wmst_user_buffer_full;
  logic           busy;
  logic           job_done;
`ifdef SOFTMAX_WR_PERF_EN
  logic [XAW-1:0] perf_stall;
`endif

  softmax_wr_pack #(
    .DW(DW), .XAW(XAW), .XDW(XDW), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .param_ena              (param_ena),
    .param_waddr            (param_waddr),
    .param_iolen            (param_iolen),
    .res_data               (res_data),
    .res_valid              (res_valid),
    .res_ready              (res_ready),
    .wmst_fixed_location    (wmst_fixed_location),
    .wmst_write_base        (wmst_write_base),
    .wmst_write_length      (wmst_write_length),
    .wmst_go                (wmst_go),
    .wmst_done              (wmst_done),
    .wmst_user_write_buffer (wmst_user_write_buffer),
    .wmst_user_buffer_data  (wmst_user_buffer_data),
    .wmst_user_buffer_full  (wmst_user_buffer_full),
    .busy                   (busy),
    .job_done               (job_done)
`ifdef SOFTMAX_WR_PERF_EN
    ,
    .perf_stall             (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int             n_tests;
  int             n_fail;
  logic [XDW-1:0] beats[$];
  logic [XAW-1:0] go_base[$];
  logic [XAW-1:0] go_len[$];
  int             cyc;
  int             job_start_cyc;
  int             done_cyc;
  int             acc_cnt;
  int             feed_left;
  logic [DW-1:0]  next_word;
  int             job_len;
  int             dly;
  bit             mst_auto;
  int             full_left;
  int             stall_at;
  int             stall_seen;
  logic [XDW-1:0] stall_exp;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [XDW-1:0] exp_beat(input int len, input int idx);
    logic [XDW-1:0] b;
    b = '0;
    for (int i = 0; i < 4; i++)
      if (idx * 4 + i < len)
        b[32*i +: 32] = 32'(idx * 4 + i + 1);
    return b;
  endfunction

  // One clock: observe at negedge, drive just after posedge.
  task automatic tick();
    bit acc;
    bit go_seen;
    @(negedge clk);
    acc     = res_valid && res_ready;
    go_seen = wmst_go;
    if (wmst_user_write_buffer) beats.push_back(wmst_user_buffer_data);
    if (go_seen) begin
      go_base.push_back(wmst_write_base);
      go_len.push_back(wmst_write_length);
    end
    if (job_done && done_cyc < 0) done_cyc = cyc;
    if (wmst_user_buffer_full) begin
      stall_seen++;
      chk("stall_push", 128'(wmst_user_write_buffer), 128'd0);
      chk("stall_ready", 128'(res_ready), 128'd0);
      chk("stall_data", 128'(wmst_user_buffer_data), 128'(stall_exp));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      if (acc_cnt == stall_at) begin
        full_left = 10;
        stall_exp = exp_beat(job_len, stall_at / 4);
        stall_at  = -1;
      end
      acc_cnt++;
      next_word++;
      feed_left--;
    end
    res_valid = (feed_left > 0);
    res_data  = next_word;
    wmst_user_buffer_full = (full_left > 0);
    if (full_left > 0) full_left--;
    wmst_done = 1'b0;
    if (go_seen && mst_auto) dly = 4;
    else if (dly > 0) begin
      dly--;
      if (dly == 0) wmst_done = 1'b1;
    end
  endtask

  task automatic begin_job(input logic [XAW-1:0] waddr, input int len, input int supply);
    beats.delete();
    go_base.delete();
    go_len.delete();
    acc_cnt    = 0;
    done_cyc   = -1;
    stall_seen = 0;
    next_word  = 32'd1;
    job_len    = len;
    feed_left  = supply;
    res_valid  = (feed_left > 0);
    res_data   = next_word;
    param_waddr   = waddr;
    param_iolen   = XAW'(len);
    param_ena     = 1'b1;
    job_start_cyc = cyc;
    tick();
    param_ena = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [XAW-1:0] waddr, input int len,
                         input int supply, input int budget);
    begin_job(waddr, len, supply);
    while (done_cyc < 0 && (cyc - job_start_cyc) < budget) tick();
    chk({tag, "_timeout"}, 128'(done_cyc >= 0), 128'd1);
    tick();
    tick();
  endtask

  task automatic check_model_beats(input string tag, input int nbeats);
    chk({tag, "_nbeats"}, 128'(beats.size()), 128'(nbeats));
    for (int i = 0; i < beats.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 128'(beats[i]), 128'(exp_beat(job_len, i)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(job_done), 128'd0);
    chk({tag, "_go"}, 128'(wmst_go), 128'd0);
    chk({tag, "_wbuf"}, 128'(wmst_user_write_buffer), 128'd0);
    chk({tag, "_base"}, 128'(wmst_write_base), 128'd0);
    chk({tag, "_len"}, 128'(wmst_write_length), 128'd0);
    chk({tag, "_ready"}, 128'(res_ready), 128'd0);
    chk({tag, "_data"}, 128'(wmst_user_buffer_data), 128'd0);
    chk({tag, "_fixed"}, 128'(wmst_fixed_location), 128'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc = 0; dly = 0; full_left = 0; stall_at = -1; stall_seen = 0;
    stall_exp = '0; mst_auto = 1'b1; feed_left = 0; next_word = 32'd1;
    acc_cnt = 0; done_cyc = -1; job_len = 0; job_start_cyc = 0;
    rst = 1'b0; param_ena = 1'b0; param_waddr = '0; param_iolen = '0;
    res_data = '0; res_valid = 1'b0; wmst_done = 1'b0; wmst_user_buffer_full = 1'b0;

    repeat (3) tick();
    check_all_zero("rst");
    rst = 1'b1;
    tick();
    tick();

    // Test 1: eight words, one burst
    run_job("t1", 32'h1000, 8, 8, 500);
    chk("t1_ngo", 128'(go_base.size()), 128'd1);
    chk("t1_base", 128'(go_base[0]), 128'h1000);
    chk("t1_len", 128'(go_len[0]), 128'd32);
    chk("t1_nbeats", 128'(beats.size()), 128'd2);
    chk("t1_beat0", 128'(beats[0]), 128'h00000004_00000003_00000002_00000001);
    chk("t1_beat1", 128'(beats[1]), 128'h00000008_00000007_00000006_00000005);
    chk("t1_idle", 128'(busy), 128'd0);

    // Test 2: partial last beat, over-supplied source
    run_job("t2", 32'h3000, 5, 7, 500);
    chk("t2_ngo", 128'(go_base.size()), 128'd1);
    chk("t2_len", 128'(go_len[0]), 128'd32);
    chk("t2_nbeats", 128'(beats.size()), 128'd2);
    chk("t2_beat0", 128'(beats[0]), 128'h00000004_00000003_00000002_00000001);
    chk("t2_beat1", 128'(beats[1]), 128'h00000000_00000000_00000000_00000005);
    chk("t2_accepted", 128'(acc_cnt), 128'd5);
    chk("t2_valid_left", 128'(res_valid), 128'd1);
    chk("t2_ready_after", 128'(res_ready), 128'd0);

    // Test 3: split into 32 + 18 beats
    run_job("t3", 32'h1000, 200, 200, 3000);
    chk("t3_ngo", 128'(go_base.size()), 128'd2);
    chk("t3_base0", 128'(go_base[0]), 128'h1000);
    chk("t3_len0", 128'(go_len[0]), 128'd512);
    chk("t3_base1", 128'(go_base[1]), 128'h1200);
    chk("t3_len1", 128'(go_len[1]), 128'd288);
    check_model_beats("t3", 50);

    // Test 4: buffer full for 10 cycles once the second beat completes
    stall_at = 7;
    run_job("t4", 32'h4000, 16, 16, 1000);
    chk("t4_stall_cycles", 128'(stall_seen), 128'd10);
    check_model_beats("t4", 4);
`ifdef SOFTMAX_WR_PERF_EN
    chk("t4_perf_stall", 128'(perf_stall), 128'd10);
`endif

    // Test 5: zero-length job
    run_job("t5", 32'h5000, 0, 0, 50);
    chk("t5_latency", 128'(done_cyc - job_start_cyc), 128'd2);
    chk("t5_ngo", 128'(go_base.size()), 128'd0);
    chk("t5_nbeats", 128'(beats.size()), 128'd0);

    // Test 6: reset while waiting for write-master done, then a clean job
    mst_auto = 1'b0;
    begin_job(32'h6000, 8, 8);
    for (int g = 0; g < 50 && go_base.size() == 0; g++) tick();
    chk("t6_go_seen", 128'(go_base.size()), 128'd1);
    tick();
    tick();
    chk("t6_busy_pre", 128'(busy), 128'd1);
    rst = 1'b0;
    #1;
    check_all_zero("t6_rst");
    feed_left = 0;
    res_valid = 1'b0;
    tick();
    rst = 1'b1;
    mst_auto = 1'b1;
    tick();
    run_job("t6b", 32'h7000, 8, 8, 500);
    chk("t6b_ngo", 128'(go_base.size()), 128'd1);
    chk("t6b_base", 128'(go_base[0]), 128'h7000);
    chk("t6b_len", 128'(go_len[0]), 128'd32);
    check_model_beats("t6b", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
